ram_write_queue_responder: RTL and testbench

//  Memory-side responder for the memory-op stage RAM port (ram_r/ram_r_addr/ram_r_line, ram_w/ram_w_addr/ram_w_line).

---
 rtl/ram_write_queue_responder_if.sv | 34 +++
 rtl/ram_write_queue_responder.sv | 137 +++++++++++++
 tb/tb_ram_write_queue_responder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_write_queue_responder_if.sv
// rtl/ram_write_queue_responder_if.sv - RAM port bundle between memory-op stage and write-queue responder
interface ram_write_queue_responder_if #(
  parameter int WQ_DEPTH = 4
);
  localparam int CNT_W = $clog2(WQ_DEPTH) + 1;

  logic             ram_r;
  logic [31:0]      ram_r_addr;
  logic [31:0]      ram_r_line;
  logic             ram_w;
  logic [31:0]      ram_w_addr;
  logic [31:0]      ram_w_line;
  logic             ram_stall;
  logic             ram_rd_err;
  logic             ram_oor;
  logic [CNT_W-1:0] wq_count;
  logic [31:0]      perf_rd;
  logic [31:0]      perf_wr;
  logic [31:0]      perf_conf;

  // Memory-op stage side: issues requests, observes data and status.
  modport master (
    output ram_r, ram_r_addr, ram_w, ram_w_addr, ram_w_line,
    input  ram_r_line, ram_stall, ram_rd_err, ram_oor, wq_count,
    input  perf_rd, perf_wr, perf_conf
  );

  // Responder side.
  modport slave (
    input  ram_r, ram_r_addr, ram_w, ram_w_addr, ram_w_line,
    output ram_r_line, ram_stall, ram_rd_err, ram_oor, wq_count,
    output perf_rd, perf_wr, perf_conf
  );
endinterface

// File: rtl/ram_write_queue_responder.sv
// rtl/ram_write_queue_responder.sv - single-port word RAM with posted FIFO write queue and read forwarding (optional RAM_PERF_EN counters)
module ram_write_queue_responder #(
  parameter int ADDR_BITS = 8,
  parameter int WQ_DEPTH  = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  ram_write_queue_responder_if.slave bus
);
  localparam int PTR_W = $clog2(WQ_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0]          mem    [DEPTH];
  logic [ADDR_BITS-1:0] q_idx  [WQ_DEPTH];
  logic [31:0]          q_data [WQ_DEPTH];

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;
  logic                 oor;

  logic [ADDR_BITS-1:0] r_idx;
  logic [ADDR_BITS-1:0] w_idx;
  logic                 r_oor;
  logic                 w_oor;
  logic                 q_full;
  logic                 do_push;
  logic                 do_pop;
  logic                 fwd_hit;
  logic [31:0]          fwd_data;
  logic [31:0]          r_line;
  logic                 rd_err;

  assign r_idx   = bus.ram_r_addr[ADDR_BITS-1:0];
  assign w_idx   = bus.ram_w_addr[ADDR_BITS-1:0];
  assign r_oor   = |bus.ram_r_addr[31:ADDR_BITS];
  assign w_oor   = |bus.ram_w_addr[31:ADDR_BITS];
  assign q_full  = (count == CNT_W'(WQ_DEPTH));

  // Out-of-range writes never enter the queue; a full queue still accepts
  // because the port is then forced to drain, freeing the head slot.
  assign do_push = bus.ram_w && !w_oor;
  assign do_pop  = (count != '0) && (!bus.ram_r || q_full);

  // Scan queued entries oldest to newest so the newest matching write wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (q_idx[head + PTR_W'(i)] == r_idx)) begin
        fwd_hit  = 1'b1;
        fwd_data = q_data[head + PTR_W'(i)];
      end
    end
  end

  // Read data select: forwarded entry, then array, else port lost to forced drain.
  always_comb begin
    r_line = '0;
    rd_err = 1'b0;
    if (bus.ram_r && !r_oor) begin
      if (fwd_hit) begin
        r_line = fwd_data;
      end else if (!q_full) begin
        r_line = mem[r_idx];
      end else begin
        r_line = 32'hAAAA_AAAA;
        rd_err = 1'b1;
      end
    end
  end

  assign bus.ram_r_line = r_line;
  assign bus.ram_rd_err = rd_err;
  assign bus.ram_stall  = (count >= CNT_W'(WQ_DEPTH - 1));
  assign bus.ram_oor    = oor;
  assign bus.wq_count   = count;

  // Queue pointers, occupancy and sticky out-of-range flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      oor   <= 1'b0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((bus.ram_r && r_oor) || (bus.ram_w && w_oor)) oor <= 1'b1;
    end
  end

  // Queue payload and array storage; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      q_idx[tail]  <= w_idx;
      q_data[tail] <= bus.ram_w_line;
    end
    if (do_pop) begin
      mem[q_idx[head]] <= q_data[head];
    end
  end

`ifdef RAM_PERF_EN
  logic [31:0] cnt_rd;
  logic [31:0] cnt_wr;
  logic [31:0] cnt_conf;

  // Free-running event counters, wrapping at 2**32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_rd   <= '0;
      cnt_wr   <= '0;
      cnt_conf <= '0;
    end else begin
      if (bus.ram_r) cnt_rd   <= cnt_rd + 1'b1;
      if (do_push)   cnt_wr   <= cnt_wr + 1'b1;
      if (rd_err)    cnt_conf <= cnt_conf + 1'b1;
    end
  end

  assign bus.perf_rd   = cnt_rd;
  assign bus.perf_wr   = cnt_wr;
  assign bus.perf_conf = cnt_conf;
`else
  assign bus.perf_rd   = 32'b0;
  assign bus.perf_wr   = 32'b0;
  assign bus.perf_conf = 32'b0;
`endif

endmodule

// File: tb/tb_ram_write_queue_responder.sv
// tb/tb_ram_write_queue_responder.sv - randomized and directed checks of ram_write_queue_responder against a queue-based model
module tb_ram_write_queue_responder;
  localparam int AB = 8;
  localparam int D  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   run = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  ram_write_queue_responder_if #(.WQ_DEPTH(D)) bus ();

  ram_write_queue_responder #(.ADDR_BITS(AB), .WQ_DEPTH(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int unsigned idx;
    logic [31:0] data;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] mmem [1 << AB];
  bit          m_oor = 1'b0;
  logic [31:0] m_prd = 0, m_pwr = 0, m_pconf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read result from the current request and the model's queue/array.
  function automatic void model_read(output logic [31:0] line, output bit err);
    bit hit;
    int unsigned a;
    line = 32'b0;
    err  = 1'b0;
    hit  = 1'b0;
    a    = bus.ram_r_addr[AB-1:0];
    if (bus.ram_r && bus.ram_r_addr[31:AB] == 0) begin
      for (int i = mq.size() - 1; i >= 0 && !hit; i--) begin
        if (mq[i].idx == a) begin
          line = mq[i].data;
          hit  = 1'b1;
        end
      end
      if (!hit) begin
        if (mq.size() < D) line = mmem[a];
        else begin
          line = 32'hAAAA_AAAA;
          err  = 1'b1;
        end
      end
    end
  endfunction

  // Model state advance at each clock edge.
  always @(posedge clk) begin
    if (rst_n) begin
      logic [31:0] l;
      bit e;
      model_read(l, e);
      if (bus.ram_r) m_prd++;
      if (e) m_pconf++;
      if ((bus.ram_r && bus.ram_r_addr[31:AB] != 0) || (bus.ram_w && bus.ram_w_addr[31:AB] != 0))
        m_oor = 1'b1;
      if (mq.size() > 0 && (!bus.ram_r || mq.size() == D)) begin
        mmem[mq[0].idx] = mq[0].data;
        void'(mq.pop_front());
      end
      if (bus.ram_w && bus.ram_w_addr[31:AB] == 0) begin
        mq.push_back('{idx: bus.ram_w_addr[AB-1:0], data: bus.ram_w_line});
        m_pwr++;
      end
    end
  end

  // Compare every output against the model once per cycle, mid-period.
  always @(negedge clk) begin
    if (rst_n && run) begin
      logic [31:0] l;
      bit e;
      model_read(l, e);
      chk("ram_r_line", bus.ram_r_line, l);
      chk("ram_rd_err", {31'b0, bus.ram_rd_err}, {31'b0, e});
      chk("ram_stall", {31'b0, bus.ram_stall}, {31'b0, mq.size() >= D - 1});
      chk("wq_count", {29'b0, bus.wq_count}, mq.size());
      chk("ram_oor", {31'b0, bus.ram_oor}, {31'b0, m_oor});
`ifdef RAM_PERF_EN
      chk("perf_rd", bus.perf_rd, m_prd);
      chk("perf_wr", bus.perf_wr, m_pwr);
      chk("perf_conf", bus.perf_conf, m_pconf);
`else
      chk("perf_rd", bus.perf_rd, 32'b0);
      chk("perf_wr", bus.perf_wr, 32'b0);
      chk("perf_conf", bus.perf_conf, 32'b0);
`endif
    end
  end

  // One request cycle: inputs change just after the rising edge, return at the falling edge.
  task automatic drive(input bit r, input logic [31:0] ra, input bit w,
                       input logic [31:0] wa, input logic [31:0] wd);
    @(posedge clk);
    #1;
    bus.ram_r      = r;
    bus.ram_r_addr = ra;
    bus.ram_w      = w;
    bus.ram_w_addr = wa;
    bus.ram_w_line = wd;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
  endtask

  initial begin
    bus.ram_r = 1'b0; bus.ram_r_addr = '0;
    bus.ram_w = 1'b0; bus.ram_w_addr = '0; bus.ram_w_line = '0;

    repeat (3) @(negedge clk);
    chk("rst_wq_count", {29'b0, bus.wq_count}, 32'd0);
    chk("rst_stall", {31'b0, bus.ram_stall}, 32'd0);
    chk("rst_oor", {31'b0, bus.ram_oor}, 32'd0);
    chk("rst_perf_rd", bus.perf_rd, 32'd0);
    #2 rst_n = 1'b1;
    run = 1'b1;

    // Give every array word a known value.
    for (int i = 0; i < (1 << AB); i++) drive(1'b0, 0, 1'b1, i, $urandom);
    idle(2);

    // Same-cycle read and write of one address.
    drive(1'b0, 0, 1'b1, 5, 32'h1);
    idle(3);
    drive(1'b1, 5, 1'b1, 5, 32'h2);
    chk("same_cycle_old", bus.ram_r_line, 32'h1);
    drive(1'b1, 5, 1'b0, 0, 0);
    chk("same_cycle_next", bus.ram_r_line, 32'h2);
    idle(3);

    // Forwarding while queued and after drain.
    drive(1'b0, 0, 1'b1, 32'h10, 32'h1111_1111);
    drive(1'b1, 32'h10, 1'b0, 0, 0);
    chk("fwd_queued", bus.ram_r_line, 32'h1111_1111);
    chk("fwd_queued_cnt", {29'b0, bus.wq_count}, 32'd1);
    idle(2);
    drive(1'b1, 32'h10, 1'b0, 0, 0);
    chk("fwd_drained", bus.ram_r_line, 32'h1111_1111);
    idle(2);

    // Fill the queue under continuous reads.
    for (int k = 0; k < D; k++) begin
      drive(1'b1, 32'h80, 1'b1, 32'h20 + k, 32'hC0DE_0000 + k);
      chk("fill_count", {29'b0, bus.wq_count}, k);
      chk("fill_stall", {31'b0, bus.ram_stall}, {31'b0, k >= D - 1});
    end
    drive(1'b1, 32'h80, 1'b0, 0, 0);
    chk("full_count", {29'b0, bus.wq_count}, D);
    chk("full_line", bus.ram_r_line, 32'hAAAA_AAAA);
    chk("full_rd_err", {31'b0, bus.ram_rd_err}, 32'd1);
    idle(6);
    for (int k = 0; k < D; k++) begin
      drive(1'b1, 32'h20 + k, 1'b0, 0, 0);
      chk("fill_landed", bus.ram_r_line, 32'hC0DE_0000 + k);
    end
    idle(2);

    // Back-to-back writes to one address land in order.
    drive(1'b0, 0, 1'b1, 7, 32'hAAAA_0001);
    drive(1'b0, 0, 1'b1, 7, 32'hBBBB_0002);
    idle(6);
    drive(1'b1, 7, 1'b0, 0, 0);
    chk("order_last", bus.ram_r_line, 32'hBBBB_0002);

    // Out-of-range write is dropped; flag is sticky.
    drive(1'b0, 0, 1'b1, 32'h100, 32'hDEAD_BEEF);
    drive(1'b0, 0, 1'b0, 0, 0);
    chk("oor_no_enq", {29'b0, bus.wq_count}, 32'd0);
    chk("oor_set", {31'b0, bus.ram_oor}, 32'd1);
    drive(1'b1, 32'h100, 1'b0, 0, 0);
    chk("oor_read", bus.ram_r_line, 32'h0);
    idle(2);
    chk("oor_sticky", {31'b0, bus.ram_oor}, 32'd1);

    // Randomized traffic, mostly on a small address set to exercise hazards.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] ra, wa;
      ra = ($urandom_range(0, 31) == 0) ? (32'h100 + $urandom_range(0, 15)) : $urandom_range(0, 15);
      wa = ($urandom_range(0, 31) == 0) ? $urandom : $urandom_range(0, 15);
      drive($urandom_range(0, 3) != 0, ra, $urandom_range(0, 1) == 1, wa, $urandom);
    end
    idle(8);

    // Asynchronous reset with three writes pending.
    drive(1'b1, 32'h90, 1'b1, 32'h30, 32'h5555_0000);
    drive(1'b1, 32'h90, 1'b1, 32'h31, 32'h5555_0001);
    drive(1'b1, 32'h90, 1'b1, 32'h32, 32'h5555_0002);
    @(posedge clk);
    #1;
    bus.ram_r = 1'b0; bus.ram_w = 1'b0;
    chk("pre_rst_count", {29'b0, bus.wq_count}, 32'd3);
    #1 rst_n = 1'b0;
    mq.delete();
    m_oor = 1'b0; m_prd = 0; m_pwr = 0; m_pconf = 0;
    #1;
    chk("async_rst_count", {29'b0, bus.wq_count}, 32'd0);
    chk("async_rst_oor", {31'b0, bus.ram_oor}, 32'd0);
    chk("async_rst_perf", bus.perf_wr, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) drive(1'b1, 32'h30 + k, 1'b0, 0, 0);
    idle(2);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
